// File: rtl/tiny_project_selector.sv
// Hosts NUM_PROJECTS tiny user projects behind one pad group: valid/ready slot selection,
// divided and gated per-slot clock, sequenced reset, registered pad routing. Optional TPS_HEARTBEAT_EN.
module tiny_project_selector #(
  parameter int NUM_PROJECTS = 4,
  parameter int IN_W         = 8,
  parameter int OUT_W        = 8,
  parameter int SEL_W        = 6,
  parameter int RST_TICKS    = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          sel_valid_i,
  input  logic [SEL_W-1:0]              sel_id_i,
  output logic                          sel_ready_o,
  input  logic [7:0]                    clk_div_i,
  input  logic [IN_W-1:0]               pad_in_i,
  output logic [NUM_PROJECTS-1:0]       proj_clk_o,
  output logic [NUM_PROJECTS-1:0]       proj_rst_o,
  output logic [NUM_PROJECTS*IN_W-1:0]  proj_in_o,
  input  logic [NUM_PROJECTS*OUT_W-1:0] proj_out_i,
  output logic [OUT_W-1:0]              pad_out_o,
  output logic [OUT_W-1:0]              pad_oeb_o,
  output logic [SEL_W-1:0]              active_id_o,
  output logic                          running_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_RUN
  } state_t;

  localparam int               RC_W        = $clog2(RST_TICKS + 1);
  localparam logic [RC_W-1:0]  RST_TICKS_C = RC_W'(RST_TICKS);
  localparam logic [SEL_W:0]   NUM_C       = (SEL_W + 1)'(NUM_PROJECTS);

  state_t                        state_q, state_d;
  logic [SEL_W-1:0]              active_q, active_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [7:0]                    div_q, div_d;
  logic                          phase_q, phase_d;
  logic [RC_W-1:0]               rise_q, rise_d;
  logic [NUM_PROJECTS-1:0]       proj_clk_q, proj_clk_d;
  logic [NUM_PROJECTS-1:0]       proj_rst_q, proj_rst_d;
  logic [NUM_PROJECTS*IN_W-1:0]  proj_in_q, proj_in_d;
  logic [OUT_W-1:0]              pad_out_q, pad_out_d;
  logic [OUT_W-1:0]              pad_oeb_q, pad_oeb_d;
  logic                          accept;
  logic                          in_range;
  logic                          wrap;
`ifdef TPS_HEARTBEAT_EN
  logic [23:0]                   hb_q, hb_d;
`endif

  assign sel_ready_o = (state_q != ST_SWITCH);
  assign running_o   = (state_q == ST_RUN);
  assign active_id_o = active_q;
  assign proj_clk_o  = proj_clk_q;
  assign proj_rst_o  = proj_rst_q;
  assign proj_in_o   = proj_in_q;
  assign pad_out_o   = pad_out_q;
  assign pad_oeb_o   = pad_oeb_q;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q + 8'd1;
    div_d    = div_q;
    phase_d  = phase_q;
    rise_d   = rise_q;
    accept   = sel_valid_i && (state_q != ST_SWITCH);
    in_range = ({1'b0, sel_id_i} < NUM_C);
    wrap     = (cnt_q == div_q);

    if (wrap) begin
      cnt_d   = 8'd0;
      phase_d = ~phase_q;
      div_d   = clk_div_i;
    end

    case (state_q)
      ST_SWITCH: begin
        // A wrap with phase low is a rising edge; with phase high, a falling edge.
        if (wrap && !phase_q && (rise_q != RST_TICKS_C)) rise_d = rise_q + 1'b1;
        if (wrap && phase_q && (rise_q == RST_TICKS_C)) state_d = ST_RUN;
      end
      default: begin
        if (accept) begin
          if (in_range) begin
            state_d  = ST_SWITCH;
            active_d = sel_id_i;
            cnt_d    = 8'd0;
            phase_d  = 1'b0;
            div_d    = clk_div_i;
            rise_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    // Clock and reset flops follow the next state so a deselected clock drops on the accepting edge.
    proj_clk_d = '0;
    proj_rst_d = '1;
    proj_in_d  = '0;
    pad_out_d  = '0;
    pad_oeb_d  = '1;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      if (active_d == SEL_W'(k)) begin
        proj_clk_d[k] = (state_d != ST_IDLE) && phase_d;
        proj_rst_d[k] = (state_d != ST_RUN);
      end
      if (active_q == SEL_W'(k)) begin
        if (state_q != ST_IDLE) proj_in_d[k*IN_W +: IN_W] = pad_in_i;
        if (state_q == ST_RUN) begin
          pad_out_d = proj_out_i[k*OUT_W +: OUT_W];
          pad_oeb_d = '0;
        end
      end
    end

`ifdef TPS_HEARTBEAT_EN
    hb_d = hb_q + 24'd1;
    if (state_q == ST_IDLE) begin
      pad_out_d[OUT_W-1] = hb_q[23];
      pad_oeb_d[OUT_W-1] = 1'b0;
    end
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      rise_q     <= '0;
      proj_clk_q <= '0;
      proj_rst_q <= '1;
      proj_in_q  <= '0;
      pad_out_q  <= '0;
      pad_oeb_q  <= '1;
`ifdef TPS_HEARTBEAT_EN
      hb_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      rise_q     <= rise_d;
      proj_clk_q <= proj_clk_d;
      proj_rst_q <= proj_rst_d;
      proj_in_q  <= proj_in_d;
      pad_out_q  <= pad_out_d;
      pad_oeb_q  <= pad_oeb_d;
`ifdef TPS_HEARTBEAT_EN
      hb_q       <= hb_d;
`endif
    end
  end

endmodule

// File: tb/tb_tiny_project_selector.sv
// Scoreboard bench for tiny_project_selector: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_tiny_project_selector;

  localparam int NP = 4;
  localparam int IW = 8;
  localparam int OW = 8;
  localparam int SW = 6;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             sel_valid_i;
  logic [SW-1:0]    sel_id_i;
  logic             sel_ready_o;
  logic [7:0]       clk_div_i;
  logic [IW-1:0]    pad_in_i;
  logic [NP-1:0]    proj_clk_o;
  logic [NP-1:0]    proj_rst_o;
  logic [NP*IW-1:0] proj_in_o;
  logic [NP*OW-1:0] proj_out_i;
  logic [OW-1:0]    pad_out_o;
  logic [OW-1:0]    pad_oeb_o;
  logic [SW-1:0]    active_id_o;
  logic             running_o;

  tiny_project_selector dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .sel_valid_i (sel_valid_i),
    .sel_id_i    (sel_id_i),
    .sel_ready_o (sel_ready_o),
    .clk_div_i   (clk_div_i),
    .pad_in_i    (pad_in_i),
    .proj_clk_o  (proj_clk_o),
    .proj_rst_o  (proj_rst_o),
    .proj_in_o   (proj_in_o),
    .proj_out_i  (proj_out_i),
    .pad_out_o   (pad_out_o),
    .pad_oeb_o   (pad_oeb_o),
    .active_id_o (active_id_o),
    .running_o   (running_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef enum {S_READY, S_RUN, S_ACT, S_PCLK, S_PRST, S_PIN, S_POUT, S_POEB} sig_e;
  typedef struct {
    int          tag;
    sig_e        sig;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] sample(sig_e s);
    case (s)
      S_READY: return 64'(sel_ready_o);
      S_RUN:   return 64'(running_o);
      S_ACT:   return 64'(active_id_o);
      S_PCLK:  return 64'(proj_clk_o);
      S_PRST:  return 64'(proj_rst_o);
      S_PIN:   return 64'(proj_in_o);
      S_POUT:  return 64'(pad_out_o);
      default: return 64'(pad_oeb_o);
    endcase
  endfunction

  // Monitor: every negedge, compare and retire the expectations due at this cycle.
  always @(negedge wb_clk_i) begin
    logic [63:0] act;
    cyc++;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].tag <= cyc) begin
        act = sample(sbq[i].sig);
        checks++;
        if (sbq[i].tag < cyc) begin
          errors++;
          $display("[TB] FAIL %s missed cycle %0d (now %0d)", sbq[i].name, sbq[i].tag, cyc);
        end else if (act !== sbq[i].exp) begin
          errors++;
          $display("[TB] FAIL %s cyc %0d got %h expected %h", sbq[i].name, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [SW-1:0] id);
    sel_valid_i = valid;
    sel_id_i    = id;
  endtask

  task automatic checkOutput(input sig_e sig, input int rel, input logic [63:0] exp, input string name);
    exp_t e;
    e.tag  = cyc + rel;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  initial begin
    int guard;
    wb_rst_i    = 1'b1;
    applyStimulus(1'b0, '0);
    clk_div_i   = 8'd1;
    pad_in_i    = 8'h3C;
    proj_out_i  = 32'h11A5_2233;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Idle after reset
    tick(9);
    checkOutput(S_READY, 1, 64'd1,     "rst_ready");
    checkOutput(S_PRST,  1, 64'hF,     "rst_proj_rst");
    checkOutput(S_PCLK,  1, 64'h0,     "rst_proj_clk");
    checkOutput(S_POEB,  1, 64'hFF,    "rst_pad_oeb");
    checkOutput(S_POUT,  1, 64'h0,     "rst_pad_out");
    checkOutput(S_RUN,   1, 64'd0,     "rst_running");
    checkOutput(S_ACT,   1, 64'd0,     "rst_active");
    checkOutput(S_PIN,   1, 64'h0,     "rst_proj_in");
    tick(2);

    // Select slot 2 with clk_div=1: period 4, RUN 8 cycles after acceptance
    applyStimulus(1'b1, 6'd2);
    checkOutput(S_READY, 1, 64'd1, "sw2_ready_pre");
    for (int k = 0; k < 9; k++)
      checkOutput(S_PCLK, k + 2, ((k % 4) >= 2) ? 64'h4 : 64'h0, "sw2_proj_clk");
    checkOutput(S_READY, 2,  64'd0,        "sw2_ready_low_first");
    checkOutput(S_ACT,   2,  64'd2,        "sw2_active");
    checkOutput(S_PIN,   3,  64'h003C0000, "sw2_proj_in");
    checkOutput(S_READY, 9,  64'd0,        "sw2_ready_low_last");
    checkOutput(S_RUN,   9,  64'd0,        "sw2_running_early");
    checkOutput(S_PRST,  9,  64'hF,        "sw2_rst_held");
    checkOutput(S_POUT,  9,  64'h0,        "sw2_pad_out_switch");
    checkOutput(S_POEB,  9,  64'hFF,       "sw2_pad_oeb_switch");
    checkOutput(S_RUN,   10, 64'd1,        "sw2_running");
    checkOutput(S_READY, 10, 64'd1,        "sw2_ready_back");
    checkOutput(S_PRST,  10, 64'hB,        "sw2_rst_release");
    checkOutput(S_POUT,  10, 64'h0,        "run2_pad_out_lat");
    checkOutput(S_POUT,  11, 64'hA5,       "run2_pad_out");
    checkOutput(S_POEB,  11, 64'h0,        "run2_pad_oeb");
    tick(1);
    applyStimulus(1'b0, '0);
    tick(14);

    // Routing in RUN with one cycle of latency
    pad_in_i   = 8'h5A;
    proj_out_i = 32'h117E_2233;
    checkOutput(S_PIN,  1, 64'h003C0000, "run2_proj_in_old");
    checkOutput(S_POUT, 1, 64'hA5,       "run2_pad_out_old");
    checkOutput(S_PIN,  2, 64'h005A0000, "run2_proj_in_new");
    checkOutput(S_POUT, 2, 64'h7E,       "run2_pad_out_new");
    tick(3);

    // Switch from slot 2 to slot 0
    applyStimulus(1'b1, 6'd0);
    checkOutput(S_PCLK,  2,  64'h0,        "sw0_clk_stop");
    checkOutput(S_PRST,  2,  64'hF,        "sw0_rst_assert");
    checkOutput(S_ACT,   2,  64'd0,        "sw0_active");
    checkOutput(S_READY, 2,  64'd0,        "sw0_ready_low");
    checkOutput(S_RUN,   2,  64'd0,        "sw0_running_low");
    checkOutput(S_POUT,  2,  64'h7E,       "sw0_pad_out_lat");
    checkOutput(S_POUT,  3,  64'h0,        "sw0_pad_out_switch");
    checkOutput(S_POEB,  3,  64'hFF,       "sw0_pad_oeb_switch");
    checkOutput(S_PIN,   3,  64'h0000005A, "sw0_proj_in");
    checkOutput(S_PCLK,  4,  64'h1,        "sw0_clk_rise");
    checkOutput(S_RUN,   9,  64'd0,        "sw0_running_early");
    checkOutput(S_RUN,   10, 64'd1,        "sw0_running");
    checkOutput(S_PRST,  10, 64'hE,        "sw0_rst_release");
    tick(1);
    applyStimulus(1'b0, '0);
    tick(14);

    // Out-of-range request deselects
    applyStimulus(1'b1, 6'd7);
    checkOutput(S_RUN,   2, 64'd0,  "desel_running");
    checkOutput(S_PRST,  2, 64'hF,  "desel_rst");
    checkOutput(S_PCLK,  2, 64'h0,  "desel_clk");
    checkOutput(S_READY, 2, 64'd1,  "desel_ready");
    checkOutput(S_ACT,   2, 64'd0,  "desel_active_hold");
    checkOutput(S_POEB,  3, 64'hFF, "desel_pad_oeb");
    checkOutput(S_POUT,  3, 64'h0,  "desel_pad_out");
    checkOutput(S_PIN,   3, 64'h0,  "desel_proj_in");
    tick(1);
    applyStimulus(1'b0, '0);
    tick(5);

    // Async reset in the middle of SWITCH to slot 3
    applyStimulus(1'b1, 6'd3);
    checkOutput(S_READY, 4, 64'd0, "abort_in_switch");
    checkOutput(S_PCLK,  4, 64'h8, "abort_clk_high");
    checkOutput(S_ACT,   4, 64'd3, "abort_active");
    tick(1);
    applyStimulus(1'b0, '0);
    tick(3);
    wb_rst_i = 1'b1;
    checkOutput(S_PCLK,  1, 64'h0,  "abort_rst_clk");
    checkOutput(S_PRST,  1, 64'hF,  "abort_rst_rst");
    checkOutput(S_READY, 1, 64'd1,  "abort_rst_ready");
    checkOutput(S_ACT,   1, 64'd0,  "abort_rst_active");
    checkOutput(S_PIN,   1, 64'h0,  "abort_rst_proj_in");
    checkOutput(S_RUN,   1, 64'd0,  "abort_rst_running");
    checkOutput(S_POEB,  1, 64'hFF, "abort_rst_pad_oeb");
    tick(2);
    wb_rst_i = 1'b0;
    tick(12);
    checkOutput(S_RUN,  1, 64'd0,  "post_rst_no_run");
    checkOutput(S_PRST, 1, 64'hF,  "post_rst_rst");

    guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout pending %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
